// File: rtl/pipe_pkg.sv
// Shared encodings for the pipeline hazard controller: register-command
// choices, the mult/div FSM state type and a packed command bundle.
package pipe_pkg;

  localparam logic [1:0] CH_FLUSH = 2'b00;
  localparam logic [1:0] CH_LOAD  = 2'b01;
  localparam logic [1:0] CH_HOLD  = 2'b10;

  localparam int MD_CNT_W = 6;

  typedef enum logic {
    IDLE    = 1'b0,
    MD_WAIT = 1'b1
  } md_state_t;

  typedef struct packed {
    logic       pc_we;
    logic [1:0] ifid;
    logic [1:0] idex;
    logic [1:0] exmem;
    logic [1:0] memwb;
  } pipe_cmd_t;

  function automatic pipe_cmd_t make_cmd(input logic       pc_we,
                                         input logic [1:0] ifid,
                                         input logic [1:0] idex,
                                         input logic [1:0] exmem,
                                         input logic [1:0] memwb);
    pipe_cmd_t c;
    c.pc_we = pc_we;
    c.ifid  = ifid;
    c.idex  = idex;
    c.exmem = exmem;
    c.memwb = memwb;
    return c;
  endfunction

endpackage

// File: rtl/md_timer.sv
// Mult/div latency timer: IDLE/MD_WAIT FSM with a 6-bit countdown that
// stays busy for load_val+1 cycles after a start.
module md_timer
  import pipe_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [MD_CNT_W-1:0] load_val,
  output logic                busy,
  output md_state_t           state
);

  md_state_t           state_next;
  logic [MD_CNT_W-1:0] count;
  logic [MD_CNT_W-1:0] count_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // The countdown ignores pipeline freezes; it only stops at zero.
  always_comb begin
    state_next = state;
    count_next = count;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = MD_WAIT;
          count_next = load_val;
        end
      end
      MD_WAIT: begin
        if (count == '0) state_next = IDLE;
        else             count_next = count - 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == MD_WAIT);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: prioritised freeze/branch/hazard/jump/run commands
// plus mult/div busy tracking. Define HAZ_PERF_CNT_EN to add the stall_cnt output.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MD_CYCLES = 32
)
(
  input  logic       clk,
  input  logic       reset,
  input  logic       dmem_wait,
  input  logic       ex_branch_taken,
  input  logic       id_jump,
  input  logic       ex_memread,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       id_md_start,
  input  logic       id_md_read,
  output logic       pc_we,
  output logic [1:0] ifid_choice,
  output logic [1:0] idex_choice,
  output logic [1:0] exmem_choice,
  output logic [1:0] memwb_choice,
  output logic       md_busy,
  output md_state_t  dbg_state
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MD_CYCLES - 1);

  logic      load_use;
  logic      md_hazard;
  logic      md_go;
  pipe_cmd_t cmd;

  assign load_use = ex_memread && (ex_rt != 5'd0) &&
                    ((id_uses_rs && (id_rs == ex_rt)) ||
                     (id_uses_rt && (id_rt == ex_rt)));

  assign md_hazard = md_busy && (id_md_read || id_md_start);

  always_comb begin
    cmd = make_cmd(1'b1, CH_LOAD, CH_LOAD, CH_LOAD, CH_LOAD);
    if (!reset)
      cmd = make_cmd(1'b0, CH_FLUSH, CH_FLUSH, CH_FLUSH, CH_FLUSH);
    else if (dmem_wait)
      cmd = make_cmd(1'b0, CH_HOLD, CH_HOLD, CH_HOLD, CH_HOLD);
    else if (ex_branch_taken)
      cmd = make_cmd(1'b1, CH_FLUSH, CH_FLUSH, CH_LOAD, CH_LOAD);
    else if (load_use || md_hazard)
      cmd = make_cmd(1'b0, CH_HOLD, CH_FLUSH, CH_LOAD, CH_LOAD);
    else if (id_jump)
      cmd = make_cmd(1'b1, CH_FLUSH, CH_LOAD, CH_LOAD, CH_LOAD);
  end

  assign pc_we        = cmd.pc_we;
  assign ifid_choice  = cmd.ifid;
  assign idex_choice  = cmd.idex;
  assign exmem_choice = cmd.exmem;
  assign memwb_choice = cmd.memwb;

  // A start only counts when the mult/div actually advances into EX.
  assign md_go = id_md_start && (cmd.idex == CH_LOAD);

  md_timer u_md_timer (
    .clk      (clk),
    .reset    (reset),
    .start    (md_go),
    .load_val (MD_LOAD),
    .busy     (md_busy),
    .state    (dbg_state)
  );

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      stall_cnt <= '0;
    else if (!pc_we) stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl with a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;
  import pipe_pkg::*;

  localparam int MDC = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       dmem_wait = 1'b0;
  logic       ex_branch_taken = 1'b0;
  logic       id_jump = 1'b0;
  logic       ex_memread = 1'b0;
  logic [4:0] ex_rt = '0;
  logic [4:0] id_rs = '0;
  logic [4:0] id_rt = '0;
  logic       id_uses_rs = 1'b0;
  logic       id_uses_rt = 1'b0;
  logic       id_md_start = 1'b0;
  logic       id_md_read = 1'b0;
  logic       pc_we;
  logic [1:0] ifid_choice, idex_choice, exmem_choice, memwb_choice;
  logic       md_busy;
  md_state_t  dbg_state;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt;
`endif

  logic [10:0] act;
  logic [10:0] exp_v;
  logic [10:0] exp_q[$];
  int          rem = 0;
  int          exp_stall = 0;
  int          checks = 0;
  int          fails = 0;

  pipe_hazard_ctrl #(.MD_CYCLES(MDC)) dut (
    .clk             (clk),
    .reset           (reset),
    .dmem_wait       (dmem_wait),
    .ex_branch_taken (ex_branch_taken),
    .id_jump         (id_jump),
    .ex_memread      (ex_memread),
    .ex_rt           (ex_rt),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rs      (id_uses_rs),
    .id_uses_rt      (id_uses_rt),
    .id_md_start     (id_md_start),
    .id_md_read      (id_md_read),
    .pc_we           (pc_we),
    .ifid_choice     (ifid_choice),
    .idex_choice     (idex_choice),
    .exmem_choice    (exmem_choice),
    .memwb_choice    (memwb_choice),
    .md_busy         (md_busy),
    .dbg_state       (dbg_state)
`ifdef HAZ_PERF_CNT_EN
    ,
    .stall_cnt       (stall_cnt)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  assign act = {pc_we, ifid_choice, idex_choice, exmem_choice, memwb_choice,
                md_busy, dbg_state == MD_WAIT};

  // Reference model: 0 reset, 1 freeze, 2 branch, 3 hazard, 4 jump, 5 run.
  function automatic int model_cause();
    bit lu;
    lu = ex_memread && (ex_rt != 5'd0) &&
         ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));
    if (!reset) return 0;
    if (dmem_wait) return 1;
    if (ex_branch_taken) return 2;
    if (lu || (rem > 0 && (id_md_read || id_md_start))) return 3;
    if (id_jump) return 4;
    return 5;
  endfunction

  function automatic logic [10:0] model_out();
    logic [8:0] c;
    logic       b;
    case (model_cause())
      0:       c = 9'b0_00_00_00_00;
      1:       c = 9'b0_10_10_10_10;
      2:       c = 9'b1_00_00_01_01;
      3:       c = 9'b0_10_00_01_01;
      4:       c = 9'b1_00_01_01_01;
      default: c = 9'b1_01_01_01_01;
    endcase
    b = reset && (rem > 0);
    return {c, b, b};
  endfunction

  task automatic model_tick();
    int cause = model_cause();
    if (cause == 1 || cause == 3) exp_stall++;
    if (!reset) begin
      rem = 0;
      exp_stall = 0;
    end else if (rem > 0) begin
      rem--;
    end else if (id_md_start && cause >= 4) begin
      rem = MDC;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  // driver tasks
  task automatic drive_idle();
    dmem_wait = 0; ex_branch_taken = 0; id_jump = 0; ex_memread = 0;
    ex_rt = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
    id_md_start = 0; id_md_read = 0;
  endtask

  task automatic drive_lu(input logic [4:0] ert, input logic [4:0] rs, input logic urs,
                          input logic [4:0] rt, input logic urt);
    ex_memread = 1; ex_rt = ert; id_rs = rs; id_uses_rs = urs; id_rt = rt; id_uses_rt = urt;
  endtask

  task automatic drive_random();
    dmem_wait       = ($urandom_range(0, 7) == 0);
    ex_branch_taken = ($urandom_range(0, 7) == 0);
    id_jump         = ($urandom_range(0, 7) == 0);
    ex_memread      = ($urandom_range(0, 2) == 0);
    ex_rt           = 5'($urandom_range(0, 3));
    id_rs           = 5'($urandom_range(0, 3));
    id_rt           = 5'($urandom_range(0, 3));
    id_uses_rs      = 1'($urandom_range(0, 1));
    id_uses_rt      = 1'($urandom_range(0, 1));
    id_md_start     = ($urandom_range(0, 5) == 0);
    id_md_read      = ($urandom_range(0, 5) == 0);
  endtask

  task automatic test_reset();
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      drive_random();
      @(negedge clk);
      checks++;
      if (act !== 11'b0) begin
        fails++;
        $display("FAIL reset_hold[%0d]: got %b expected %b", i, act, 11'b0);
      end
      tick();
    end
    drive_idle();
    reset = 1;
    @(negedge clk);
    exp_v = model_out();
    checks++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL reset_release: got %b expected %b", act, exp_v);
    end
    tick();
  endtask

  task automatic test_load_use();
    for (int k = 0; k < 5; k++) begin
      drive_idle();
      case (k)
        0: drive_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        1: drive_lu(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
        2: drive_lu(5'd7, 5'd1, 1'b1, 5'd7, 1'b1);
        3: drive_lu(5'd7, 5'd7, 1'b0, 5'd7, 1'b0);
        default: begin drive_lu(5'd9, 5'd9, 1'b1, 5'd0, 1'b0); ex_memread = 0; end
      endcase
      @(negedge clk);
      exp_v = model_out();
      checks++;
      if (act !== exp_v) begin
        fails++;
        $display("FAIL load_use[%0d]: got %b expected %b", k, act, exp_v);
      end
      tick();
    end
    drive_idle();
  endtask

  task automatic test_branch_jump();
    for (int k = 0; k < 4; k++) begin
      drive_idle();
      case (k)
        0: begin ex_branch_taken = 1; drive_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0); end
        1: begin ex_branch_taken = 1; id_jump = 1; end
        2: id_jump = 1;
        default: begin id_jump = 1; drive_lu(5'd3, 5'd0, 1'b0, 5'd3, 1'b1); end
      endcase
      @(negedge clk);
      exp_v = model_out();
      checks++;
      if (act !== exp_v) begin
        fails++;
        $display("FAIL branch_jump[%0d]: got %b expected %b", k, act, exp_v);
      end
      tick();
    end
    drive_idle();
  endtask

  task automatic test_md_timing();
    int busy_seen = 0;
    int stall_seen = 0;
    drive_idle();
    id_md_start = 1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      exp_v = model_out();
      checks++;
      if (act !== exp_v) begin
        fails++;
        $display("FAIL md_timing[%0d]: got %b expected %b", c, act, exp_v);
      end
      if (md_busy === 1'b1) busy_seen++;
      if (c > 0 && pc_we === 1'b0) stall_seen++;
      tick();
      id_md_start = 0;
      id_md_read  = 1;
    end
    drive_idle();
    checks++;
    if (busy_seen != MDC) begin
      fails++;
      $display("FAIL md_busy_len: got %0d expected %0d", busy_seen, MDC);
    end
    checks++;
    if (stall_seen != MDC) begin
      fails++;
      $display("FAIL md_read_stall_len: got %0d expected %0d", stall_seen, MDC);
    end
  endtask

  task automatic test_freeze_md();
    drive_idle();
    id_md_start = 1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      exp_v = model_out();
      checks++;
      if (act !== exp_v) begin
        fails++;
        $display("FAIL freeze_md[%0d]: got %b expected %b", c, act, exp_v);
      end
      tick();
      id_md_start = 0;
      dmem_wait = (c >= 1 && c <= 3);
    end
    checks++;
    if (md_busy !== 1'b0) begin
      fails++;
      $display("FAIL freeze_md_expiry: got %b expected 0", md_busy);
    end
    drive_idle();
  endtask

  task automatic test_md_restart();
    drive_idle();
    id_md_start = 1;
    for (int c = 0; c < 12; c++) begin
      if (c == 6) id_md_start = 0;
      @(negedge clk);
      exp_v = model_out();
      checks++;
      if (act !== exp_v) begin
        fails++;
        $display("FAIL md_restart[%0d]: got %b expected %b", c, act, exp_v);
      end
      tick();
    end
    drive_idle();
  endtask

  task automatic test_blocked_start();
    for (int k = 0; k < 3; k++) begin
      drive_idle();
      id_md_start = 1;
      case (k)
        0: ex_branch_taken = 1;
        1: dmem_wait = 1;
        default: drive_lu(5'd4, 5'd4, 1'b1, 5'd0, 1'b0);
      endcase
      tick();
      drive_idle();
      @(negedge clk);
      exp_v = model_out();
      checks++;
      if (act !== exp_v || md_busy !== 1'b0) begin
        fails++;
        $display("FAIL blocked_start[%0d]: got %b expected %b", k, act, exp_v);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_md();
    drive_idle();
    id_md_start = 1;
    tick();
    id_md_start = 0;
    tick();
    reset = 0;
    rem = 0;
    #1;
    checks++;
    if (act !== 11'b0) begin
      fails++;
      $display("FAIL reset_mid_md: got %b expected %b", act, 11'b0);
    end
    tick();
    reset = 1;
    id_md_read = 1;
    @(negedge clk);
    exp_v = model_out();
    checks++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL reset_mid_md_release: got %b expected %b", act, exp_v);
    end
    tick();
    drive_idle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      drive_random();
      exp_q.push_back(model_out());
      @(negedge clk);
      exp_v = exp_q.pop_front();
      checks++;
      if (act !== exp_v) begin
        fails++;
        $display("FAIL random[%0d]: got %b expected %b", c, act, exp_v);
      end
      tick();
    end
    drive_idle();
`ifdef HAZ_PERF_CNT_EN
    @(negedge clk);
    checks++;
    if (stall_cnt !== 32'(exp_stall)) begin
      fails++;
      $display("FAIL random_stall_cnt: got %0d expected %0d", stall_cnt, exp_stall);
    end
`endif
  endtask

`ifdef HAZ_PERF_CNT_EN
  task automatic test_stall_cnt();
    drive_idle();
    reset = 0;
    tick();
    reset = 1;
    tick();
    drive_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    tick();
    tick();
    drive_idle();
    dmem_wait = 1;
    tick();
    tick();
    tick();
    drive_idle();
    @(negedge clk);
    checks++;
    if (stall_cnt !== 32'd5 || exp_stall != 5) begin
      fails++;
      $display("FAIL stall_cnt: got %0d expected 5 (model %0d)", stall_cnt, exp_stall);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_load_use();
    test_branch_jump();
    test_md_timing();
    test_freeze_md();
    test_md_restart();
    test_blocked_start();
    test_reset_mid_md();
    test_random();
`ifdef HAZ_PERF_CNT_EN
    test_stall_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter MD_CYCLES, default 32: multiply/divide latency in cycles, legal range 2..63.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port dmem_wait, input, 1 bit: data memory not ready; freezes the pipeline.
REQ-005 SHALL have port ex_branch_taken, input, 1 bit: branch resolved taken in EX.
REQ-006 SHALL have port id_jump, input, 1 bit: jump decoded in ID.
REQ-007 SHALL have ports ex_memread (input, 1 bit) and ex_rt (input, 5 bits): the EX-stage instruction is a load, and its destination register.
REQ-008 SHALL have ports id_rs and id_rt (input, 5 bits each) and id_uses_rs and id_uses_rt (input, 1 bit each): ID source operands and their valid flags.
REQ-009 SHALL have ports id_md_start (input, 1 bit, mult/div in ID) and id_md_read (input, 1 bit, mfhi/mflo in ID).
REQ-010 SHALL have port pc_we, output, 1 bit: PC write enable.
REQ-011 SHALL have ports ifid_choice, idex_choice, exmem_choice and memwb_choice, each output, 2 bits: pipeline-register command; 00 flush, 01 load, 10 hold.
REQ-012 SHALL have port md_busy, output, 1 bit: mult/div result pending.

Function
REQ-013 SHALL detect load_use when ex_memread=1, ex_rt!=0 and ex_rt equals any of id_rs (with id_uses_rs=1) or id_rt (with id_uses_rt=1).
REQ-014 SHALL detect md_hazard when md_busy=1 and id_md_read or id_md_start is 1.
REQ-015 SHALL resolve commands by priority, highest first: freeze, branch, hazard, jump, run.
REQ-016 Freeze (dmem_wait=1) SHALL drive all four choices to 10 and pc_we=0.
REQ-017 Branch (ex_branch_taken=1) SHALL drive ifid and idex to 00, exmem and memwb to 01, and pc_we=1.
REQ-018 Hazard (load_use or md_hazard) SHALL drive ifid to 10, idex to 00, exmem and memwb to 01, and pc_we=0.
REQ-019 Jump (id_jump=1) SHALL drive ifid to 00, the other three choices to 01, and pc_we=1.
REQ-020 Run (none of the above) SHALL drive all four choices to 01 and pc_we=1.
REQ-021 Choices and pc_we SHALL be combinational from inputs and state, with zero-cycle latency.
REQ-022 SHALL implement an FSM with states IDLE and MD_WAIT, where md_busy=1 exactly in MD_WAIT.
REQ-023 SHALL transition IDLE->MD_WAIT and load the counter with MD_CYCLES-1 when id_md_start=1, idex_choice=01 and the start is not stalled.
REQ-024 In MD_WAIT, the counter SHALL decrement every cycle, including freeze cycles; at counter=0 the FSM SHALL return to IDLE, so md_busy lasts exactly MD_CYCLES cycles.
REQ-025 A branch flush SHALL NOT cancel an already-started MD_WAIT.
REQ-026 A start flushed by branch priority in the same cycle SHALL NOT enter MD_WAIT.
REQ-027 id_md_start arriving while md_busy=1 SHALL stall until IDLE, then start on that cycle.
REQ-028 The counter SHALL be 6 bits wide and SHALL never wrap below 0.

Reset
REQ-029 While reset=0, the block SHALL hold state IDLE, counter 0, md_busy=0, pc_we=0, and all choices 00.
REQ-030 Reset assertion mid-MD_WAIT SHALL abort the operation immediately; the first cycle after release SHALL be IDLE.

Configuration
REQ-031 With HAZ_PERF_CNT_EN defined, SHALL add output stall_cnt (32 bits), reset to 0, which increments once per cycle with pc_we=0 and reset=1 and wraps 0xFFFFFFFF->0.
REQ-032 Without HAZ_PERF_CNT_EN, the stall_cnt port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-033 Choice encodings (CH_FLUSH=2'b00, CH_LOAD=2'b01, CH_HOLD=2'b10) and the FSM state type SHALL live in shared package pipe_pkg.
REQ-034 The MD countdown counter SHALL be sub-module md_timer (inputs start, load value; output busy).

Verification
REQ-035 Load-use: ex_memread=1, ex_rt=5, id_rs=5, id_uses_rs=1 -> one cycle of pc_we=0, ifid=10, idex=00; ex_rt=0 -> run commands (01 on all).
REQ-036 Branch and hazard together: ex_branch_taken=1 with load_use=1 -> ifid=00, idex=00, pc_we=1.
REQ-037 MD timing: MD_CYCLES=4, id_md_start pulse -> md_busy high exactly 4 cycles; id_md_read during busy -> stalls until md_busy falls.
REQ-038 Freeze: dmem_wait=1 for 3 cycles during MD_WAIT -> all choices 10, pc_we=0, counter still expires on schedule.
REQ-039 Reset: reset=0 at MD_WAIT cycle 2 -> immediate md_busy=0 and all choices 00; IDLE after release.
REQ-040 With HAZ_PERF_CNT_EN defined: 2 hazard cycles plus 3 freeze cycles -> stall_cnt=5.
